// File: rtl/ovc_status_ctrl_if.sv
// rtl/ovc_status_ctrl_if.sv - event inputs and status outputs between router allocation logic and ovc_status_ctrl
interface ovc_status_ctrl_if #(
    parameter int PORT_NUM           = 4,
    parameter int VC_NUM_PER_PORT    = 4,
    parameter int PORT_SEL_BCD_WIDTH = $clog2(PORT_NUM),
    parameter int VC_BCD_WIDTH       = $clog2(VC_NUM_PER_PORT)
);
    localparam int OVC_NUM = PORT_NUM * VC_NUM_PER_PORT;

    logic                          alloc_en;
    logic [PORT_SEL_BCD_WIDTH-1:0] alloc_port_bcd;
    logic [VC_BCD_WIDTH-1:0]       alloc_vc_bcd;
    logic                          flit_wr_en;
    logic [PORT_SEL_BCD_WIDTH-1:0] flit_port_bcd;
    logic [VC_BCD_WIDTH-1:0]       flit_vc_bcd;
    logic                          flit_is_tail;
    logic [OVC_NUM-1:0]            credit_in;
    logic [OVC_NUM-1:0]            ovc_busy;
    logic [OVC_NUM-1:0]            ovc_credit_avail;
    logic [OVC_NUM-1:0]            ovc_empty;
    logic [2:0]                    ovc_err;

    modport master (
        output alloc_en, alloc_port_bcd, alloc_vc_bcd,
        output flit_wr_en, flit_port_bcd, flit_vc_bcd, flit_is_tail,
        output credit_in,
        input  ovc_busy, ovc_credit_avail, ovc_empty, ovc_err
    );

    modport slave (
        input  alloc_en, alloc_port_bcd, alloc_vc_bcd,
        input  flit_wr_en, flit_port_bcd, flit_vc_bcd, flit_is_tail,
        input  credit_in,
        output ovc_busy, ovc_credit_avail, ovc_empty, ovc_err
    );
endinterface

// File: rtl/ovc_status_ctrl.sv
// rtl/ovc_status_ctrl.sv - per-OVC busy/credit status keeper; OVC_STATUS_ERR_CHK_EN enables sticky ovc_err
module ovc_status_ctrl #(
    parameter int PORT_NUM           = 4,
    parameter int VC_NUM_PER_PORT    = 4,
    parameter int BUFFER_NUM_PER_VC  = 4,
    parameter int PORT_SEL_BCD_WIDTH = $clog2(PORT_NUM),
    parameter int VC_BCD_WIDTH       = $clog2(VC_NUM_PER_PORT),
    parameter int CREDIT_WIDTH       = $clog2(BUFFER_NUM_PER_VC + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    ovc_status_ctrl_if.slave   st
);
    localparam int OVC_NUM = PORT_NUM * VC_NUM_PER_PORT;
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(BUFFER_NUM_PER_VC);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE = CREDIT_WIDTH'(1);

    // Out-of-range indices decode to an all-zero vector, so the event is dropped.
    function automatic logic [OVC_NUM-1:0] decode_ovc(
        input logic                          en,
        input logic [PORT_SEL_BCD_WIDTH-1:0] port,
        input logic [VC_BCD_WIDTH-1:0]       vc
    );
        logic [OVC_NUM-1:0] oh;
        int                 idx;
        logic               in_range;
        oh       = '0;
        idx      = int'(port) * VC_NUM_PER_PORT + int'(vc);
        in_range = (int'(port) < PORT_NUM) && (int'(vc) < VC_NUM_PER_PORT);
        for (int i = 0; i < OVC_NUM; i++) begin
            oh[i] = en && in_range && (idx == i);
        end
        return oh;
    endfunction

    logic [OVC_NUM-1:0]      alloc_oh;
    logic [OVC_NUM-1:0]      flit_oh;
    logic [OVC_NUM-1:0]      tail_oh;
    logic [OVC_NUM-1:0]      busy_q;
    logic [OVC_NUM-1:0]      busy_d;
    logic [CREDIT_WIDTH-1:0] cnt_q [OVC_NUM];
    logic [CREDIT_WIDTH-1:0] cnt_d [OVC_NUM];
    logic [OVC_NUM-1:0]      avail_vec;
    logic [OVC_NUM-1:0]      empty_vec;

    assign alloc_oh = decode_ovc(st.alloc_en, st.alloc_port_bcd, st.alloc_vc_bcd);
    assign flit_oh  = decode_ovc(st.flit_wr_en, st.flit_port_bcd, st.flit_vc_bcd);
    assign tail_oh  = flit_oh & {OVC_NUM{st.flit_is_tail}};

    // A tail and an alloc in the same cycle hand the OVC straight to the new packet.
    assign busy_d = alloc_oh | (busy_q & ~tail_oh);

    always_comb begin
        for (int i = 0; i < OVC_NUM; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flit_oh[i] && !st.credit_in[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CREDIT_ONE;
            end else if (st.credit_in[i] && !flit_oh[i] && (cnt_q[i] != CREDIT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CREDIT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            for (int i = 0; i < OVC_NUM; i++) begin
                cnt_q[i] <= CREDIT_MAX;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < OVC_NUM; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        avail_vec = '0;
        empty_vec = '0;
        for (int i = 0; i < OVC_NUM; i++) begin
            avail_vec[i] = (cnt_q[i] != '0);
            empty_vec[i] = (cnt_q[i] == CREDIT_MAX);
        end
    end

    assign st.ovc_busy         = busy_q;
    assign st.ovc_credit_avail = avail_vec;
    assign st.ovc_empty        = empty_vec;

`ifdef OVC_STATUS_ERR_CHK_EN
    logic [2:0] err_q;
    logic       realloc_hit;
    logic       underflow_hit;
    logic       overflow_hit;

    // Net-zero cycles (flit and credit together) never flag, even at the limits.
    always_comb begin
        realloc_hit   = 1'b0;
        underflow_hit = 1'b0;
        overflow_hit  = 1'b0;
        for (int i = 0; i < OVC_NUM; i++) begin
            if (alloc_oh[i] && busy_q[i] && !tail_oh[i]) begin
                realloc_hit = 1'b1;
            end
            if (flit_oh[i] && !st.credit_in[i] && (cnt_q[i] == '0)) begin
                underflow_hit = 1'b1;
            end
            if (st.credit_in[i] && !flit_oh[i] && (cnt_q[i] == CREDIT_MAX)) begin
                overflow_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 3'b000;
        end else begin
            err_q <= err_q | {realloc_hit, underflow_hit, overflow_hit};
        end
    end

    assign st.ovc_err = err_q;
`else
    assign st.ovc_err = 3'b000;
`endif
endmodule

// File: tb/tb_ovc_status_ctrl.sv
// tb/tb_ovc_status_ctrl.sv - directed and randomized check of ovc_status_ctrl against a credit/busy model
module tb_ovc_status_ctrl;
    localparam int PORT_NUM          = 4;
    localparam int VC_NUM_PER_PORT   = 4;
    localparam int BUFFER_NUM_PER_VC = 4;
    localparam int PW                = $clog2(PORT_NUM);
    localparam int VW                = $clog2(VC_NUM_PER_PORT);
    localparam int CW                = $clog2(BUFFER_NUM_PER_VC + 1);
    localparam int OVC_NUM           = PORT_NUM * VC_NUM_PER_PORT;
`ifdef OVC_STATUS_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    ovc_status_ctrl_if #(
        .PORT_NUM(PORT_NUM), .VC_NUM_PER_PORT(VC_NUM_PER_PORT),
        .PORT_SEL_BCD_WIDTH(PW), .VC_BCD_WIDTH(VW)
    ) bus ();

    ovc_status_ctrl #(
        .PORT_NUM(PORT_NUM), .VC_NUM_PER_PORT(VC_NUM_PER_PORT),
        .BUFFER_NUM_PER_VC(BUFFER_NUM_PER_VC), .PORT_SEL_BCD_WIDTH(PW),
        .VC_BCD_WIDTH(VW), .CREDIT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .st(bus.slave)
    );

    always #5 clk = ~clk;

    int    tests  = 0;
    int    failed = 0;
    string phase  = "reset";

    int       m_cred [OVC_NUM];
    bit       m_busy [OVC_NUM];
    bit [2:0] m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < OVC_NUM; i++) begin
            m_cred[i] = BUFFER_NUM_PER_VC;
            m_busy[i] = 1'b0;
        end
        m_err = 3'b000;
    endtask

    task automatic model_update(input bit a_en, input int a_idx, input bit f_en, input int f_idx,
                                input bit tail, input logic [OVC_NUM-1:0] cr);
        for (int i = 0; i < OVC_NUM; i++) begin
            bit al;
            bit fl;
            int c;
            al = a_en && (a_idx == i);
            fl = f_en && (f_idx == i);
            if (al && m_busy[i] && !(fl && tail)) m_err[2] = 1'b1;
            if (al) m_busy[i] = 1'b1;
            else if (fl && tail) m_busy[i] = 1'b0;
            c = m_cred[i] + int'(cr[i]) - int'(fl);
            if (c < 0) begin
                c = 0;
                m_err[1] = 1'b1;
            end
            if (c > BUFFER_NUM_PER_VC) begin
                c = BUFFER_NUM_PER_VC;
                m_err[0] = 1'b1;
            end
            m_cred[i] = c;
        end
    endtask

    task automatic check_all();
        logic [OVC_NUM-1:0] eb;
        logic [OVC_NUM-1:0] ea;
        logic [OVC_NUM-1:0] ee;
        logic [2:0]         er;
        for (int i = 0; i < OVC_NUM; i++) begin
            eb[i] = m_busy[i];
            ea[i] = (m_cred[i] > 0);
            ee[i] = (m_cred[i] == BUFFER_NUM_PER_VC);
        end
        er = ERR_EN ? m_err : 3'b000;
        check({phase, ":busy"},  32'(bus.ovc_busy),         32'(eb));
        check({phase, ":avail"}, 32'(bus.ovc_credit_avail), 32'(ea));
        check({phase, ":empty"}, 32'(bus.ovc_empty),        32'(ee));
        check({phase, ":err"},   32'(bus.ovc_err),          32'(er));
    endtask

    function automatic logic [OVC_NUM-1:0] bit_of(input int i);
        return OVC_NUM'(1) << i;
    endfunction

    // One clock of events; ports/VCs are given as (port, vc) and mapped port-major.
    task automatic step(input bit a_en, input int a_p, input int a_v,
                        input bit f_en, input int f_p, input int f_v, input bit tail,
                        input logic [OVC_NUM-1:0] cr);
        bus.alloc_en       = a_en;
        bus.alloc_port_bcd = PW'(a_p);
        bus.alloc_vc_bcd   = VW'(a_v);
        bus.flit_wr_en     = f_en;
        bus.flit_port_bcd  = PW'(f_p);
        bus.flit_vc_bcd    = VW'(f_v);
        bus.flit_is_tail   = tail;
        bus.credit_in      = cr;
        @(posedge clk);
        #1;
        bus.alloc_en     = 1'b0;
        bus.flit_wr_en   = 1'b0;
        bus.flit_is_tail = 1'b0;
        bus.credit_in    = '0;
        model_update(a_en, a_p * VC_NUM_PER_PORT + a_v, f_en, f_p * VC_NUM_PER_PORT + f_v, tail, cr);
        check_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ":busy"},  32'(bus.ovc_busy),         32'h0);
        check({tag, ":avail"}, 32'(bus.ovc_credit_avail), 32'hFFFF);
        check({tag, ":empty"}, 32'(bus.ovc_empty),        32'hFFFF);
        check({tag, ":err"},   32'(bus.ovc_err),          32'h0);
    endtask

    initial begin
        bus.alloc_en       = 1'b0;
        bus.alloc_port_bcd = '0;
        bus.alloc_vc_bcd   = '0;
        bus.flit_wr_en     = 1'b0;
        bus.flit_port_bcd  = '0;
        bus.flit_vc_bcd    = '0;
        bus.flit_is_tail   = 1'b0;
        bus.credit_in      = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_reset_values("rst");

        phase = "alloc";
        step(1, 2, 1, 0, 0, 0, 0, '0);
        check("busy9_set", 32'(bus.ovc_busy[9]), 32'd1);
        step(0, 0, 0, 1, 2, 1, 0, '0);
        step(0, 0, 0, 1, 2, 1, 0, '0);
        step(0, 0, 0, 1, 2, 1, 1, '0);
        check("busy9_clr",  32'(bus.ovc_busy[9]),         32'd0);
        check("avail9",     32'(bus.ovc_credit_avail[9]), 32'd1);
        check("empty9_lo",  32'(bus.ovc_empty[9]),        32'd0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, bit_of(9));
        check("empty9_hi",  32'(bus.ovc_empty[9]),        32'd1);

        phase = "exhaust";
        repeat (4) step(0, 0, 0, 1, 0, 0, 0, '0);
        check("avail0_lo", 32'(bus.ovc_credit_avail[0]), 32'd0);
        step(0, 0, 0, 1, 0, 0, 0, '0);
        check("avail0_sat", 32'(bus.ovc_credit_avail[0]), 32'd0);
        check("err_undf",   32'(bus.ovc_err[1]),          32'(ERR_EN));

        phase = "simul";
        repeat (2) step(0, 0, 0, 1, 1, 1, 0, '0);
        step(0, 0, 0, 1, 1, 1, 0, bit_of(5));
        step(1, 1, 1, 0, 0, 0, 0, '0);
        step(1, 1, 1, 1, 1, 1, 1, '0);
        check("busy5_handover", 32'(bus.ovc_busy[5]), 32'd1);
        check("no_realloc",     32'(bus.ovc_err[2]),  32'd0);

        phase = "illegal";
        step(0, 0, 0, 0, 0, 0, 0, bit_of(3));
        check("empty3_sat", 32'(bus.ovc_empty[3]), 32'd1);
        check("err_ovf",    32'(bus.ovc_err[0]),   32'(ERR_EN));
        step(1, 1, 3, 0, 0, 0, 0, '0);
        step(1, 1, 3, 0, 0, 0, 0, '0);
        check("busy7",       32'(bus.ovc_busy[7]), 32'd1);
        check("err_realloc", 32'(bus.ovc_err[2]),  32'(ERR_EN));

        phase = "rand1";
        for (int n = 0; n < 250; n++) begin
            step($urandom_range(0, 2) == 0, int'($urandom_range(0, PORT_NUM - 1)),
                 int'($urandom_range(0, VC_NUM_PER_PORT - 1)),
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, PORT_NUM - 1)),
                 int'($urandom_range(0, VC_NUM_PER_PORT - 1)), $urandom_range(0, 3) == 0,
                 OVC_NUM'($urandom) & OVC_NUM'($urandom));
        end

        phase = "midrst";
        step(1, 3, 2, 1, 0, 1, 0, '0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_all();

        phase = "rand2";
        for (int n = 0; n < 250; n++) begin
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, PORT_NUM - 1)),
                 int'($urandom_range(0, VC_NUM_PER_PORT - 1)),
                 $urandom_range(0, 2) != 0, int'($urandom_range(0, PORT_NUM - 1)),
                 int'($urandom_range(0, VC_NUM_PER_PORT - 1)), $urandom_range(0, 2) == 0,
                 OVC_NUM'($urandom) & OVC_NUM'($urandom) & OVC_NUM'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/ovc_status_ctrl.md
# ovc_status_ctrl

Per-output-VC status keeper for the VC-based mesh router. It tracks, for every output port × VC pair, whether the OVC is allocated to a packet and how many downstream buffer credits remain. It publishes these as flat, port-major status vectors that the router's OVC status select muxes consume. It is the write/update side of the OVC status path: allocation, flit-send and credit-return events come in here, and one-bit-per-OVC status goes out.

## Interface
Parameters:
- PORT_NUM, 4, number of output ports
- VC_NUM_PER_PORT, 4, VCs per output port
- BUFFER_NUM_PER_VC, 4, downstream input-buffer depth per VC (credit maximum)
- PORT_SEL_BCD_WIDTH, log2(PORT_NUM), binary port index width
- VC_BCD_WIDTH, log2(VC_NUM_PER_PORT), binary VC index width
- CREDIT_WIDTH, log2(BUFFER_NUM_PER_VC+1), per-OVC credit counter width
- OVC_NUM (local), PORT_NUM*VC_NUM_PER_PORT

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- alloc_en  input  1  VC allocation grant this cycle
- alloc_port_bcd  input  PORT_SEL_BCD_WIDTH  port of granted OVC
- alloc_vc_bcd  input  VC_BCD_WIDTH  VC of granted OVC
- flit_wr_en  input  1  flit sent into an OVC this cycle
- flit_port_bcd  input  PORT_SEL_BCD_WIDTH  port of sent flit
- flit_vc_bcd  input  VC_BCD_WIDTH  VC of sent flit
- flit_is_tail  input  1  sent flit is a tail (qualified by flit_wr_en)
- credit_in  input  OVC_NUM  credit-return pulses, bit port*VC_NUM_PER_PORT+vc
- ovc_busy  output  OVC_NUM  OVC allocated to a packet
- ovc_credit_avail  output  OVC_NUM  credit counter > 0
- ovc_empty  output  OVC_NUM  credit counter == BUFFER_NUM_PER_VC (downstream buffer drained)
- ovc_err  output  3  sticky {realloc, underflow, overflow}; see Configuration

## Operation
- Index mapping for all vectors: idx = port*VC_NUM_PER_PORT + vc (port-major). This layout matches the select muxes exactly.
- Event decode: alloc_en and flit_wr_en each decode their binary indices to a one-hot OVC_NUM vector. If the port index is ≥ PORT_NUM, the event is ignored.
- Busy bit per OVC:
  - Set on alloc.
  - Cleared on a flit_wr_en with flit_is_tail.
  - Tail and alloc on the same OVC in the same cycle: busy stays 1. The new packet takes over.
  - Alloc to an OVC that is already busy, with no tail that cycle: ignored; flags realloc.
- Credit counter per OVC:
  - Flit only: −1.
  - credit_in only: +1.
  - Both in the same cycle: unchanged.
  - Flit at 0: saturates at 0; flags underflow.
  - Credit at BUFFER_NUM_PER_VC: saturates; flags overflow.
- All OVCs update independently and in parallel. credit_in may have any number of bits set at once.
- Status outputs are decoded from the registered busy bits and counters.

## Timing
- Reset (async assert, sync release is system-provided):
  - ovc_busy = 0.
  - All counters = BUFFER_NUM_PER_VC.
  - ovc_credit_avail = all 1s, ovc_empty = all 1s.
  - ovc_err = 0.
- Latency: an event sampled at edge N is visible on the outputs after edge N (1-cycle).
- No handshake. Inputs are single-cycle pulses; each cycle a pulse is high counts as one event.
- A single OVC can accept one flit per cycle indefinitely while credits > 0.
- Reset mid-packet discards all state. No partial recovery.

## Configuration
- OVC_STATUS_ERR_CHK_EN defined:
  - ovc_err bits set on the illegal events listed above.
  - Bits are sticky until reset.
  - ovc_err updates with the same 1-cycle latency.
- Not defined:
  - ovc_err is tied to 0 and the detection logic is omitted.
  - Saturation and ignore behaviour are unchanged.

## Test plan
- Reset check: release reset → ovc_busy=0, ovc_credit_avail=16'hFFFF, ovc_empty=16'hFFFF, ovc_err=0 (default parameters).
- Alloc/release: alloc port 2 VC 1 (bit 9) → ovc_busy[9]=1 next cycle. Then 3 flits, the last tail → ovc_busy[9]=0, counter 1, ovc_credit_avail[9]=1, ovc_empty[9]=0. Then 3 credit_in[9] pulses → ovc_empty[9]=1.
- Credit exhaustion: send 4 flits to bit 0 with no credits returned → ovc_credit_avail[0]=0. Then a fifth flit → counter stays 0, and ovc_err[1]=1 when the macro is defined.
- Simultaneous events: flit and credit_in on bit 5 in the same cycle, counter at 2 → stays 2. Tail and new alloc on bit 5 in the same cycle → ovc_busy[5]=1.
- Illegal events: credit_in[3] at full → counter stays 4, ovc_err[0]=1. Alloc of busy bit 7 → no change, ovc_err[2]=1. Without the macro, ovc_err stays 0 for both.
- Reset mid-operation: assert reset_n=0 with several OVCs busy and partially drained → all outputs return to reset values immediately, asynchronously.
